pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max consecutive MEM_WAIT cycles before fault (range 1..255).
REQ-002 Parameter: CNT_W, default 16, width of stall-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 ex_MemRead  in  1  instruction in EX is a load.
REQ-008 ex_rd  in  5  destination register of instruction in EX.
REQ-009 ex_redirect  in  1  EX resolves a taken branch, JAL or JALR.
REQ-010 mem_req  in  1  instruction in MEM accesses data memory (MemRead|MemWrite).
REQ-011 mem_ready  in  1  data memory completes access this cycle.
REQ-012 PC_IFWrite  out  1  PC and IF/ID may update.
REQ-013 IF_ID_flush  out  1  IF/ID loads a NOP.
REQ-014 ID_EX_flush  out  1  ID/EX loads a bubble (all control zero).
REQ-015 pipe_hold  out  1  ID/EX and EX/MEM hold current contents.
REQ-016 MEM_WB_bubble  out  1  MEM/WB loads a bubble.
REQ-017 mem_fault  out  1  sticky memory-timeout fault.
REQ-018 stall_cnt  out  CNT_W  saturating count of cycles with PC_IFWrite=0.

Function
REQ-019 FSM states: RUN, MEM_WAIT, FAULT; control outputs are combinational from state and inputs.
REQ-020 load_use = ex_MemRead & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-021 mem_stall = mem_req & ~mem_ready.
REQ-022 Priority per cycle: FAULT > mem_stall > ex_redirect > load_use > normal.
REQ-023 Normal: PC_IFWrite=1, all flush/hold/bubble outputs 0.
REQ-024 mem_stall (RUN or MEM_WAIT): PC_IFWrite=0, pipe_hold=1, MEM_WB_bubble=1, flushes 0; redirect and load_use are not acted on and re-evaluate after release, because EX is held.
REQ-025 ex_redirect without mem_stall: PC_IFWrite=1 (target loaded), IF_ID_flush=1, ID_EX_flush=1; a coincident load_use is ignored.
REQ-026 load_use alone: PC_IFWrite=0, ID_EX_flush=1, IF_ID_flush=0, for exactly the one cycle it is true.
REQ-027 RUN -> MEM_WAIT when mem_stall; wait counter (8-bit) cleared on entry, incremented each MEM_WAIT cycle with mem_stall.
REQ-028 MEM_WAIT -> RUN in the cycle after mem_ready=1 is sampled; the mem_ready cycle itself produces normal/redirect/load_use outputs.
REQ-029 MEM_WAIT -> FAULT when wait counter equals MEM_TIMEOUT and mem_stall is still 1.
REQ-030 FAULT: PC_IFWrite=0, pipe_hold=1, MEM_WB_bubble=1, mem_fault=1; exits only by reset.
REQ-031 stall_cnt increments on each cycle PC_IFWrite=0, saturating at all-ones; no wrap-around.
REQ-032 mem_req deasserted during MEM_WAIT is treated as mem_ready (return to RUN).

Reset
REQ-033 rst_n low: state=RUN, wait counter=0, stall_cnt=0, mem_fault=0, immediately, independent of clk.
REQ-034 During reset combinational outputs take normal values (PC_IFWrite=1, others 0) given idle inputs; reset mid-MEM_WAIT or in FAULT returns to RUN.

Structure
REQ-035 State encoding, MEM_TIMEOUT default and pipeline-control widths live in the shared CPU package beside the ALU/opcode constants.
REQ-036 One sub-module, hazard_detect, computes load_use combinationally; FSM and counters stay in pipe_ctrl.

Verification
REQ-037 ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle PC_IFWrite=0, ID_EX_flush=1, stall_cnt 0->1.
REQ-038 Same with ex_rd=0 -> no stall, all outputs normal.
REQ-039 ex_redirect=1 and load_use=1 together -> IF_ID_flush=1, ID_EX_flush=1, PC_IFWrite=1.
REQ-040 mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_hold=1 and MEM_WB_bubble=1 for 3 cycles, RUN after, stall_cnt=3.
REQ-041 mem_ready held 0 with MEM_TIMEOUT=4 -> FAULT after 4 wait cycles, mem_fault=1 sticky; rst_n pulse low asynchronously clears it.
REQ-042 CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU constants: ALU/opcode encodings plus pipeline-control types and widths.
package pipe_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_FAULT
  } pipe_state_t;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;
  localparam int WAIT_CNT_W      = 8;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_dep(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst);
    return used && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  load_use
);

  assign load_use = ex_MemRead &&
                    (reg_dep(id_use_rs1, id_rs1, ex_rd) || reg_dep(id_use_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout fault, branch
// redirect flushing, load-use bubbles and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  PC_IFWrite,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  pipe_hold,
  output logic                  MEM_WB_bubble,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_state_t           state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  load_use;
  logic                  mem_stall;

  hazard_detect u_hazard_detect (
    .ex_MemRead (ex_MemRead),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .load_use   (load_use)
  );

  // A dropped mem_req while waiting also reads as "not stalled", releasing the wait.
  assign mem_stall = mem_req && !mem_ready;
  assign mem_fault = (state == ST_FAULT);

  always_comb begin
    PC_IFWrite    = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    pipe_hold     = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (state == ST_FAULT || mem_stall) begin
      PC_IFWrite    = 1'b0;
      pipe_hold     = 1'b1;
      MEM_WB_bubble = 1'b1;
    end else if (ex_redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_IFWrite  = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // wait_cnt counts MEM_WAIT cycles already spent stalled; timeout fires once it reaches MEM_TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_stall) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT)) begin
            state <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!PC_IFWrite && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance and a small one (timeout 4, 4-bit counter) share inputs.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_MemRead = 1'b0;
  logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_a, ifid_a, idex_a, hold_a, bub_a, fault_a;
  logic [15:0] cnt_a;
  logic        pc_s, ifid_s, idex_s, hold_s, bub_s, fault_s;
  logic [3:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] NORM  = 5'b10000;
  localparam logic [4:0] LU    = 5'b00100;
  localparam logic [4:0] REDIR = 5'b11100;
  localparam logic [4:0] MEMST = 5'b00011;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_IFWrite(pc_a), .IF_ID_flush(ifid_a), .ID_EX_flush(idex_a), .pipe_hold(hold_a),
    .MEM_WB_bubble(bub_a), .mem_fault(fault_a), .stall_cnt(cnt_a)
  );

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_IFWrite(pc_s), .IF_ID_flush(ifid_s), .ID_EX_flush(idex_s), .pipe_hold(hold_s),
    .MEM_WB_bubble(bub_s), .mem_fault(fault_s), .stall_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mrd;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, redir, req, rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic mrd, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic redir, logic req, logic rdy,
                              logic [4:0] exp);
    vec_t v;
    v.mrd = mrd; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    ex_MemRead = v.mrd; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_redirect = v.redir;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_stall;
    vec_t idle, lu5;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    lu5  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, LU);

    vecs[0]  = idle;
    vecs[1]  = lu5;
    vecs[2]  = idle;
    vecs[3]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, NORM);
    vecs[4]  = mk(1, 7, 3, 7, 1, 1, 0, 0, 0, LU);
    vecs[5]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, NORM);
    vecs[6]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, REDIR);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, REDIR);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMST);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, MEMST);
    vecs[10] = mk(1, 5, 5, 0, 1, 0, 0, 1, 0, MEMST);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, REDIR);
    vecs[12] = idle;
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMST);
    vecs[15] = idle;
    vecs[16] = lu5;

    apply_stimulus(idle);
    #3;
    check_output("reset_ctl", {pc_a, ifid_a, idex_a, hold_a, bub_a}, NORM);
    check_output("reset_cnt", cnt_a, 0);
    check_output("reset_fault", fault_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_stall = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check_output($sformatf("vec%0d_cnt", i), cnt_a, exp_stall);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_ctl", i), {pc_a, ifid_a, idex_a, hold_a, bub_a}, vecs[i].exp);
      check_output($sformatf("vec%0d_ctl_s", i), {pc_s, ifid_s, idex_s, hold_s, bub_s}, vecs[i].exp);
      check_output($sformatf("vec%0d_fault", i), fault_a, 0);
      if (vecs[i].exp[4] == 1'b0) exp_stall++;
    end
    @(negedge clk);
    check_output("table_final_cnt", cnt_a, exp_stall);

    // Three-cycle memory stall, then release on mem_ready.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMST));
      #1 check_output($sformatf("memwait%0d_ctl", k), {pc_a, ifid_a, idex_a, hold_a, bub_a}, MEMST);
    end
    @(negedge clk);
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NORM));
    #1 check_output("memready_ctl", {pc_a, ifid_a, idex_a, hold_a, bub_a}, NORM);
    @(negedge clk);
    apply_stimulus(idle);
    #1 check_output("memafter_ctl", {pc_a, ifid_a, idex_a, hold_a, bub_a}, NORM);
    check_output("memafter_cnt", cnt_a, 3);

    // Timeout: small instance faults, default instance keeps waiting.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMST));
      #1 check_output($sformatf("timeout%0d_fault", k), fault_s, 0);
    end
    @(negedge clk);
    check_output("timeout_fault_set", fault_s, 1);
    check_output("timeout_default_nofault", fault_a, 0);
    apply_stimulus(idle);
    #1;
    check_output("fault_hold_ctl", {pc_s, ifid_s, idex_s, hold_s, bub_s}, MEMST);
    check_output("default_release_ctl", {pc_a, ifid_a, idex_a, hold_a, bub_a}, NORM);
    @(negedge clk);
    check_output("fault_sticky", fault_s, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_fault", fault_s, 0);
    check_output("async_rst_ctl", {pc_s, ifid_s, idex_s, hold_s, bub_s}, NORM);
    check_output("async_rst_cnt", cnt_s, 0);
    rst_n = 1'b1;

    // Twenty load-use stalls: 4-bit counter saturates, 16-bit keeps counting.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 14 || k == 15) check_output($sformatf("sat_cnt_k%0d", k), cnt_s, k);
      apply_stimulus(lu5);
      #1 check_output($sformatf("sat%0d_ctl", k), {pc_a, ifid_a, idex_a, hold_a, bub_a}, LU);
    end
    @(negedge clk);
    apply_stimulus(idle);
    check_output("sat_final_s", cnt_s, 15);
    check_output("sat_final_a", cnt_a, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
